instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage between the program counter and decode. Samples the current PC, issues a single-outstanding read to instruction memory, holds the returned 32-bit instruction for decode under a valid/ready handshake, and tells the program counter when it may advance. Supports flush (branch redirect), misaligned-PC and memory-error faults, and a retired-fetch counter.

## Interface
- ADDR_W, 64, PC / memory address width
- INSTR_W, 32, instruction width
- CNT_W, 32, width of fetch_count

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (reset == 0 resets on the clock edge)
- pc  in  ADDR_W  current PC from the program counter
- fetch_en  in  1  permission to start a new fetch
- flush  in  1  discard the fetch in progress
- imem_req  out  1  one-cycle read request
- imem_addr  out  ADDR_W  read address, stable while a fetch is outstanding
- imem_rvalid  in  1  read data valid
- imem_rdata  in  INSTR_W  read data
- imem_err  in  1  bus error, qualified by imem_rvalid
- instr  out  INSTR_W  fetched instruction
- instr_pc  out  ADDR_W  PC of instr
- instr_valid  out  1  instr/instr_pc/instr_fault valid
- instr_fault  out  1  misaligned PC or bus error on this fetch
- instr_ready  in  1  decode accepts
- pc_advance  out  1  program counter may update this edge
- fetch_count  out  CNT_W  accepted fetches, wraps

## Operation
- States: IDLE, REQ, WAIT, VALID. At most one request outstanding.
- IDLE: if fetch_en && !flush: addr_q <= pc. If pc[1:0] == 0 -> REQ; else -> VALID with instr = 0, instr_fault = 1, no memory request.
- REQ: imem_req = 1, imem_addr = addr_q; -> WAIT. flush here sets drop flag (request still issued).
- WAIT: on imem_rvalid: if drop or flush -> IDLE, data discarded, drop cleared. Else capture imem_rdata, instr_fault <= imem_err, -> VALID. flush without rvalid sets drop, stays WAIT.
- VALID: instr_valid = 1, instr/instr_pc/instr_fault stable. flush -> IDLE, no advance (flush beats instr_ready). Else instr_ready -> pc_advance = 1, fetch_count += 1, -> IDLE.
- pc_advance = (state == VALID) && instr_ready && !flush; combinational; otherwise 0.
- imem_rvalid outside WAIT is ignored (covers late responses after reset).
- fetch_count increments on every pc_advance including faulted fetches; wraps 2^CNT_W-1 -> 0.
- Reset: state IDLE, drop 0, imem_req 0, imem_addr 0, instr 0, instr_pc 0, instr_valid 0, instr_fault 0, pc_advance 0, fetch_count 0. Reset mid-fetch abandons the request.

## Timing
- imem_req, imem_addr, instr, instr_pc, instr_valid, instr_fault are registered; pc_advance is combinational from state, instr_ready, flush.
- Aligned fetch, memory rvalid k >= 1 cycles after the REQ cycle, decode ready: pc sampled edge 0; imem_req high cycle 1; rvalid cycle 1+k; instr_valid from cycle 2+k; pc_advance same cycle if instr_ready. Minimum 4 cycles per instruction at k = 1.
- Misaligned: instr_valid the cycle after sampling; no imem_req.
- imem_rvalid in the REQ cycle itself is not accepted.
- imem_addr holds addr_q from REQ until the next IDLE sample.
- After pc_advance the FSM is in IDLE next cycle and samples the updated pc.

## Test plan
- Reset then fetch_en=1, pc=0x1000, rvalid 1 cycle after req with rdata=0x00500093, instr_ready=1 -> imem_req one cycle with addr 0x1000; instr_valid with instr=0x00500093, instr_pc=0x1000; pc_advance one cycle; fetch_count=1.
- Backpressure: instr_ready=0 for 5 cycles in VALID -> instr stable, pc_advance=0 throughout; advance on cycle instr_ready=1.
- Flush in WAIT, then rvalid rdata=0xDEADBEEF -> no instr_valid, return to IDLE, fetch_count unchanged; next fetch of pc=0x2000 completes normally. Repeat with flush and rvalid in the same cycle -> same result.
- pc=0x1002 -> no imem_req, instr_valid with instr_fault=1, instr=0; rvalid with imem_err=1 on pc=0x1004 -> instr_fault=1, pc_advance on accept.
- Flush and instr_ready together in VALID -> pc_advance=0, count unchanged; reset asserted in WAIT, late rvalid after release -> ignored, outputs at reset values.
- fetch_count preloaded by 2^32-1 accepted fetches (or CNT_W=4, 16 fetches) -> wraps to 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: samples the PC and issues one outstanding memory read.
// It holds the instruction for decode under valid/ready and tells the PC when to advance.
module instruction_fetch #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               fetch_en,
    input  logic               flush,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_err,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               instr_fault,
    input  logic               instr_ready,
    output logic               pc_advance,
    output logic [CNT_W-1:0]   fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID
    } state_e;

    state_e             state_q, state_d;
    logic               drop_q, drop_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               valid_q, valid_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Flush outranks decode acceptance, so a redirected fetch never retires.
    assign pc_advance = (state_q == S_VALID) && instr_ready && !flush;

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        drop_d     = drop_q;
        req_d      = 1'b0;
        addr_d     = addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        count_d    = count_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_en && !flush) begin
                    addr_d = pc;
                    if (pc[1:0] == 2'b00) begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                    end else begin
                        // Misaligned PC faults immediately without touching memory.
                        state_d    = S_VALID;
                        valid_d    = 1'b1;
                        instr_d    = '0;
                        fault_d    = 1'b1;
                        instr_pc_d = pc;
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                if (flush) drop_d = 1'b1;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    drop_d = 1'b0;
                    if (drop_q || flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_VALID;
                        valid_d    = 1'b1;
                        instr_d    = imem_rdata;
                        fault_d    = imem_err;
                        instr_pc_d = addr_q;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            S_VALID: begin
                if (flush) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (instr_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
        if (!reset) begin
            state_q    <= S_IDLE;
            drop_q     <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            count_q    <= count_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign instr_fault = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_instruction_fetch;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [ADDR_W-1:0]  pc = '0;
    logic               fetch_en = 1'b0;
    logic               flush = 1'b0;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rvalid = 1'b0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               imem_err = 1'b0;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_fault;
    logic               instr_ready = 1'b0;
    logic               pc_advance;
    logic [CNT_W-1:0]   fetch_count;

    instruction_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_fault (instr_fault),
        .instr_ready (instr_ready),
        .pc_advance  (pc_advance),
        .fetch_count (fetch_count)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: a request pulse, an outstanding read, or a held result.
    logic               m_req = 1'b0;
    logic               m_outst = 1'b0;
    logic               m_drop = 1'b0;
    logic [ADDR_W-1:0]  m_addr = '0;
    logic               m_valid = 1'b0;
    logic [INSTR_W-1:0] m_instr = '0;
    logic [ADDR_W-1:0]  m_pc = '0;
    logic               m_fault = 1'b0;
    logic [CNT_W-1:0]   m_count = '0;

    always @(posedge clock) begin
        if (!reset) begin
            m_req <= 1'b0; m_outst <= 1'b0; m_drop <= 1'b0; m_addr <= '0;
            m_valid <= 1'b0; m_instr <= '0; m_pc <= '0; m_fault <= 1'b0; m_count <= '0;
        end else begin
            m_req <= 1'b0;
            if (m_req) begin
                m_outst <= 1'b1;
                if (flush) m_drop <= 1'b1;
            end else if (m_outst) begin
                if (imem_rvalid) begin
                    m_outst <= 1'b0;
                    m_drop  <= 1'b0;
                    if (!(m_drop || flush)) begin
                        m_valid <= 1'b1;
                        m_instr <= imem_rdata;
                        m_fault <= imem_err;
                        m_pc    <= m_addr;
                    end
                end else if (flush) begin
                    m_drop <= 1'b1;
                end
            end else if (m_valid) begin
                if (flush) m_valid <= 1'b0;
                else if (instr_ready) begin
                    m_valid <= 1'b0;
                    m_count <= m_count + 1'b1;
                end
            end else if (fetch_en && !flush) begin
                m_addr <= pc;
                if (pc[1:0] == 2'b00) m_req <= 1'b1;
                else begin
                    m_valid <= 1'b1;
                    m_instr <= '0;
                    m_fault <= 1'b1;
                    m_pc    <= pc;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("m_imem_req", imem_req, m_req);
            check("m_imem_addr", imem_addr, m_addr);
            check("m_instr_valid", instr_valid, m_valid);
            check("m_pc_advance", pc_advance, m_valid && instr_ready && !flush);
            check("m_fetch_count", fetch_count, m_count);
            if (m_valid) begin
                check("m_instr", instr, m_instr);
                check("m_instr_pc", instr_pc, m_pc);
                check("m_instr_fault", instr_fault, m_fault);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Leaves the FSM in its request cycle.
    task automatic start_fetch(input logic [ADDR_W-1:0] addr);
        fetch_en = 1'b1;
        pc       = addr;
        cyc();
        fetch_en = 1'b0;
    endtask

    task automatic respond(input logic [INSTR_W-1:0] data, input logic err);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        imem_err    = err;
        cyc();
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        reset  = 1'b1;
        cmp_en = 1'b1;
        settle();
        check("reset_valid", instr_valid, 0);
        check("reset_req", imem_req, 0);
        check("reset_count", fetch_count, 0);

        // Basic aligned fetch, rvalid one cycle after the request.
        instr_ready = 1'b1;
        start_fetch(64'h1000);
        settle();
        check("basic_req", imem_req, 1);
        check("basic_addr", imem_addr, 64'h1000);
        cyc();
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        settle();
        check("basic_req_low", imem_req, 0);
        cyc();
        imem_rvalid = 1'b0;
        settle();
        check("basic_valid", instr_valid, 1);
        check("basic_instr", instr, 32'h0050_0093);
        check("basic_pc", instr_pc, 64'h1000);
        check("basic_adv", pc_advance, 1);
        cyc();
        settle();
        check("basic_count", fetch_count, 1);
        check("basic_adv_low", pc_advance, 0);

        // Backpressure for five cycles.
        instr_ready = 1'b0;
        start_fetch(64'h1004);
        cyc();
        respond(32'h1234_5678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            settle();
            check("bp_instr", instr, 32'h1234_5678);
            check("bp_adv", pc_advance, 0);
            cyc();
        end
        instr_ready = 1'b1;
        settle();
        check("bp_adv_go", pc_advance, 1);
        cyc();
        settle();
        check("bp_count", fetch_count, 2);

        // Flush in WAIT, response a cycle later is discarded.
        start_fetch(64'h3000);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        respond(32'hDEAD_BEEF, 1'b0);
        cyc();
        settle();
        check("flushw_valid", instr_valid, 0);
        check("flushw_count", fetch_count, 2);
        start_fetch(64'h2000);
        cyc();
        respond(32'hCAFE_0001, 1'b0);
        settle();
        check("after_flush_instr", instr, 32'hCAFE_0001);
        check("after_flush_pc", instr_pc, 64'h2000);
        check("after_flush_adv", pc_advance, 1);
        cyc();

        // Flush and rvalid in the same cycle.
        start_fetch(64'h3000);
        cyc();
        flush = 1'b1;
        respond(32'hDEAD_BEEF, 1'b0);
        flush = 1'b0;
        cyc();
        settle();
        check("flushs_valid", instr_valid, 0);
        check("flushs_count", fetch_count, 3);
        start_fetch(64'h2000);
        cyc();
        respond(32'hCAFE_0002, 1'b0);
        cyc();
        settle();
        check("flushs_next_count", fetch_count, 4);

        // Misaligned PC: immediate fault, no request.
        instr_ready = 1'b0;
        start_fetch(64'h1002);
        settle();
        check("mis_req", imem_req, 0);
        check("mis_valid", instr_valid, 1);
        check("mis_fault", instr_fault, 1);
        check("mis_instr", instr, 0);
        check("mis_pc", instr_pc, 64'h1002);
        instr_ready = 1'b1;
        settle();
        check("mis_adv", pc_advance, 1);
        cyc();
        settle();
        check("mis_count", fetch_count, 5);

        // Bus error.
        start_fetch(64'h1004);
        cyc();
        respond(32'h0BAD_F00D, 1'b1);
        settle();
        check("err_fault", instr_fault, 1);
        check("err_adv", pc_advance, 1);
        cyc();
        settle();
        check("err_count", fetch_count, 6);

        // Flush beats instr_ready in VALID.
        start_fetch(64'h4000);
        cyc();
        respond(32'h1111_1111, 1'b0);
        flush = 1'b1;
        settle();
        check("fr_adv", pc_advance, 0);
        cyc();
        flush = 1'b0;
        settle();
        check("fr_valid", instr_valid, 0);
        check("fr_count", fetch_count, 6);

        // Reset in WAIT, then a late response.
        start_fetch(64'h5000);
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        respond(32'h7777_7777, 1'b0);
        settle();
        check("rst_valid", instr_valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_instr", instr, 0);
        check("rst_count", fetch_count, 0);

        // Counter wrap with back-to-back misaligned fetches (2 cycles each).
        fetch_en = 1'b1; pc = 64'h2; instr_ready = 1'b1;
        repeat (30) cyc();
        settle();
        check("wrap_15", fetch_count, 4'hF);
        cyc();
        cyc();
        settle();
        check("wrap_0", fetch_count, 0);
        fetch_en = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(199) != 0);
            fetch_en    = ($urandom_range(3) != 0);
            flush       = ($urandom_range(9) == 0);
            instr_ready = $urandom_range(1);
            pc          = {$urandom, $urandom};
            if ($urandom_range(3) != 0) pc[1:0] = 2'b00;
            imem_rvalid = ($urandom_range(2) == 0);
            imem_rdata  = $urandom;
            imem_err    = ($urandom_range(3) == 0);
            cyc();
        end
        reset = 1'b1; fetch_en = 1'b0; flush = 1'b0; imem_rvalid = 1'b0;
        cyc();
        cyc();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
